// File: rtl/jt10_adpcm_mul_pkg.sv
// Shared jt10 ADPCM definitions: FSM encoding and counter sizing.
// Used by both the restoring divider and the shift-add multiplier.
package jt10_adpcm_mul_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_ADD  = 2'd2;

   typedef enum logic [1:0] {
      IDLE = S_IDLE,
      RUN  = S_RUN,
      ADD  = S_ADD
   } state_t;

   function automatic int clog2(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 32; i++)
         if (((n - 1) >> i) != 0) w = i + 1;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/jt10_adpcm_mul.sv
// Shift-add multiply-accumulate p = b*d + r, one bit per cen cycle.
// Define JT10_ADPCM_MUL_SAT_EN to register a saturated p_sat and ovf.
module jt10_adpcm_mul
   import jt10_adpcm_mul_pkg::*;
#(
   parameter int dw = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cen,
   input  logic            start,
   input  logic [dw-1:0]   b,
   input  logic [dw-1:0]   d,
   input  logic [dw-1:0]   r,
   output logic [2*dw-1:0] p,
   output logic [dw-1:0]   p_sat,
   output logic            ovf,
   output logic            working,
   output logic            done
);

   localparam int cw = clog2(dw);

   state_t          st;
   state_t          st_nx;
   logic [2*dw-1:0] acc;
   logic [cw-1:0]   cnt;
   logic [dw-1:0]   breg;
   logic [dw-1:0]   rreg;
   logic [dw:0]     hi;
   logic [2*dw-1:0] p_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   st <= IDLE;
      else if (cen) st <= st_nx;
   end

   always_comb begin
      st_nx   = st;
      working = (st != IDLE);
      if (start) begin
         st_nx = RUN;
      end else begin
         case (st)
            RUN:     if (cnt == '0) st_nx = ADD;
            ADD:     st_nx = IDLE;
            default: st_nx = st;
         endcase
      end
   end

   // hi keeps the carry so the shifted accumulator never loses a bit
   always_comb begin
      hi     = {1'b0, acc[2*dw-1:dw]}
             + {1'b0, (acc[0] ? breg : {dw{1'b0}})};
      p_next = acc + {{dw{1'b0}}, rreg};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc  <= '0;
         cnt  <= '0;
         breg <= '0;
         rreg <= '0;
         p    <= '0;
         done <= 1'b0;
`ifdef JT10_ADPCM_MUL_SAT_EN
         ovf   <= 1'b0;
         p_sat <= '0;
`endif
      end else if (cen) begin
         done <= 1'b0;
         if (start) begin
            breg <= b;
            rreg <= r;
            acc  <= {{dw{1'b0}}, d};
            cnt  <= cw'(dw - 1);
         end else begin
            case (st)
               RUN: begin
                  acc <= {hi, acc[dw-1:1]};
                  if (cnt != '0) cnt <= cnt - cw'(1);
               end
               ADD: begin
                  p    <= p_next;
                  done <= 1'b1;
`ifdef JT10_ADPCM_MUL_SAT_EN
                  ovf   <= |p_next[2*dw-1:dw];
                  p_sat <= (|p_next[2*dw-1:dw]) ? {dw{1'b1}}
                                                 : p_next[dw-1:0];
`endif
               end
               default: ;
            endcase
         end
      end
   end

`ifndef JT10_ADPCM_MUL_SAT_EN
   assign p_sat = p[dw-1:0];
   assign ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_jt10_adpcm_mul.sv
// Self-checking bench for jt10_adpcm_mul (dw=16), random plus directed.
// Honours JT10_ADPCM_MUL_SAT_EN when the build defines it.
module tb_jt10_adpcm_mul;

   localparam int dw = 16;
`ifdef JT10_ADPCM_MUL_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cen;
   logic          start;
   logic [15:0]   b, d, r;
   logic [31:0]   p;
   logic [15:0]   p_sat;
   logic          ovf, working, done;

   int n_cmp = 0;
   int n_bad = 0;
   int mode  = 0;
   int ph    = 0;
   int w_cnt = 0;
   bit saw_done = 1'b0;

   jt10_adpcm_mul #(.dw(dw)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .start(start),
      .b(b), .d(d), .r(r),
      .p(p), .p_sat(p_sat), .ovf(ovf),
      .working(working), .done(done)
   );

   always #5 clk = ~clk;

   // reference: count down dw+1 cen edges, then publish b*d+r
   int          m_left;
   logic [31:0] m_p, m_pend;
   logic        m_done;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left <= 0;
         m_p    <= '0;
         m_pend <= '0;
         m_done <= 1'b0;
      end else if (cen) begin
         m_done <= 1'b0;
         if (start) begin
            m_left <= dw + 1;
            m_pend <= {16'd0, b} * {16'd0, d} + {16'd0, r};
         end else if (m_left == 1) begin
            m_p    <= m_pend;
            m_done <= 1'b1;
            m_left <= 0;
         end else if (m_left > 1) begin
            m_left <= m_left - 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic        e_ovf;
      logic [15:0] e_sat;
      if (rst_n) begin
         e_ovf = SAT ? (m_p[31:16] != 16'd0) : 1'b0;
         e_sat = (SAT && e_ovf) ? 16'hFFFF : m_p[15:0];
         chk("m_p", p, m_p);
         chk("m_done", done, m_done);
         chk("m_working", working, m_left != 0);
         chk("m_ovf", ovf, e_ovf);
         chk("m_psat", p_sat, e_sat);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (working) w_cnt++;
      if (done) saw_done = 1'b1;
      case (mode)
         0: cen = 1'b1;
         1: begin
            ph  = (ph + 1) % 4;
            cen = (ph == 0);
         end
         default: cen = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic do_start(input logic [15:0] bb, dd, rr);
      b = bb;
      d = dd;
      r = rr;
      start = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if (cen) begin
            w_cnt = 0;
            saw_done = 1'b0;
            step();
            break;
         end
         step();
      end
      start = 1'b0;
      b = 16'($urandom);
      d = 16'($urandom);
      r = 16'($urandom);
   endtask

   task automatic wait_done(output int k);
      bit ok;
      logic c;
      k  = 0;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         c = cen;
         step();
         if (c) k++;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("done_timeout", 0, 1);
   endtask

   initial begin
      int k;
      int a;
      logic [15:0] rb, rd, rr;
      rst_n = 1'b0;
      cen   = 1'b1;
      start = 1'b0;
      b = '0;
      d = '0;
      r = '0;
      #12;
      chk("rst_p", p, 0);
      chk("rst_working", working, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", ovf, 0);
      rst_n = 1'b1;
      step();
      step();

      mode = 0;
      do_start(16'd7, 16'd9, 16'd3);
      wait_done(k);
      chk("basic_lat", k, 17);
      chk("basic_work", w_cnt, 17);
      chk("basic_p", p, 66);
      chk("basic_psat", p_sat, 66);
      step();
      chk("basic_pulse", done, 0);

      a = 50000;
      do_start(16'd123, 16'(a / 123), 16'(a % 123));
      wait_done(k);
      chk("rt_d", a / 123, 406);
      chk("rt_p", p, 50000);
      chk("rt_ovf", ovf, 0);

      do_start(16'hFFFF, 16'hFFFF, 16'hFFFF);
      wait_done(k);
      chk("ext_p", p, 32'hFFFF0000);
      chk("ext_ovf", ovf, SAT ? 1 : 0);
      chk("ext_psat", p_sat, SAT ? 16'hFFFF : 16'h0000);

      mode = 1;
      do_start(16'd100, 16'd655, 16'd36);
      wait_done(k);
      chk("cen_lat", k, 17);
      chk("cen_p", p, 32'h00010000);

      mode = 0;
      do_start(16'd5, 16'd5, 16'd0);
      repeat (8) step();
      chk("rs_nodone", saw_done, 0);
      do_start(16'd2, 16'd3, 16'd1);
      wait_done(k);
      chk("rs_lat", k, 17);
      chk("rs_p", p, 7);

      do_start(16'd300, 16'd400, 16'd5);
      repeat (5) step();
      rst_n = 1'b0;
      #1;
      chk("ar_working", working, 0);
      chk("ar_done", done, 0);
      chk("ar_p", p, 0);
      chk("ar_ovf", ovf, 0);
      #2;
      rst_n = 1'b1;
      step();

      do_start(16'h0000, 16'h1234, 16'hABCD);
      wait_done(k);
      chk("zero_lat", k, 17);
      chk("zero_p", p, 32'h0000ABCD);

      for (int n = 0; n < 40; n++) begin
         mode = $urandom_range(0, 2);
         rb = 16'($urandom);
         rd = 16'($urandom);
         rr = 16'($urandom);
         if (n % 8 == 0) rd = 16'd0;
         do_start(16'($urandom), 16'($urandom), 16'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(0, 15)) step();
            do_start(rb, rd, rr);
         end else begin
            do_start(rb, rd, rr);
         end
         wait_done(k);
         chk("rnd_p", p, {16'd0, rb} * {16'd0, rd} + {16'd0, rr});
      end

      mode = 0;
      repeat (3) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
